// File: rtl/key_event_arb.sv
// Multi-key front-panel controller: synchronizes and debounces KEY_NUM active-low
// keys, queues one pending event per key and serves them round-robin on a valid/ready stream.
module key_event_arb #(
  parameter int KEY_NUM    = 4,
  parameter int CLK_FRE    = 50,
  parameter int SCAN_CYC   = CLK_FRE * 1000,
  parameter int STABLE_CNT = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [KEY_NUM-1:0]         key_in,
  output logic [KEY_NUM-1:0]         key_state,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(KEY_NUM)-1:0] evt_id,
  output logic                       evt_drop
);

  localparam int IW = $clog2(KEY_NUM);
  localparam int TW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam int DW = $clog2(STABLE_CNT);

  localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_CYC - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(STABLE_CNT - 1);
  localparam logic [IW-1:0] GRANT_INIT = IW'(KEY_NUM - 1);

  logic [KEY_NUM-1:0] sync1_q, sync2_q;
  logic [KEY_NUM-1:0] p;

  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic               tick;

  logic [DW-1:0]      deb_cnt_q [KEY_NUM];
  logic [DW-1:0]      deb_cnt_d [KEY_NUM];
  logic [KEY_NUM-1:0] key_state_q, key_state_d;
  logic [KEY_NUM-1:0] key_prev_q;

  logic [KEY_NUM-1:0] press;
  logic [KEY_NUM-1:0] pending_q, pending_d;
  logic [KEY_NUM-1:0] grant_mask;
  logic [KEY_NUM-1:0] drop_vec;
  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [IW-1:0]      grant_idx;
  logic               grant_found;
  logic               slot_free;

  logic               evt_valid_q, evt_valid_d;
  logic [IW-1:0]      evt_id_q, evt_id_d;
  logic               evt_drop_q;

  // Raw pins are active-low; everything downstream works in "1 = pressed".
  assign p         = ~sync2_q;
  assign press     = key_state_q & ~key_prev_q;
  assign slot_free = ~evt_valid_q | evt_ready;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // NOTE: every variable gets a default at the top of a combinational block so
  // that no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    key_state_d = key_state_q;
    for (int i = 0; i < KEY_NUM; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (tick) begin
        if (p[i] == key_state_q[i]) begin
          deb_cnt_d[i] = '0;
        end else if (deb_cnt_q[i] == DEB_LAST) begin
          key_state_d[i] = ~key_state_q[i];
          deb_cnt_d[i]   = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic [IW-1:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    // Rotating search starting just after the last key served.
    for (int k = 1; k <= KEY_NUM; k++) begin
      cand = IW'((int'(last_grant_q) + k) % KEY_NUM);
      if (slot_free && pending_q[cand] && !grant_found) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end

    grant_mask = '0;
    if (grant_found) grant_mask[grant_idx] = 1'b1;

    // A new press on the key being granted this cycle re-arms it instead of dropping.
    drop_vec  = press & pending_q & ~grant_mask;
    pending_d = (pending_q & ~grant_mask) | press;

    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    last_grant_d = last_grant_q;
    if (slot_free) begin
      evt_valid_d = grant_found;
      if (grant_found) begin
        evt_id_d     = grant_idx;
        last_grant_d = grant_idx;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from the values present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      tick_cnt_q   <= '0;
      key_state_q  <= '0;
      key_prev_q   <= '0;
      pending_q    <= '0;
      last_grant_q <= GRANT_INIT;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_drop_q   <= 1'b0;
      for (int i = 0; i < KEY_NUM; i++) deb_cnt_q[i] <= '0;
    end else begin
      sync1_q      <= key_in;
      sync2_q      <= sync1_q;
      tick_cnt_q   <= tick_cnt_d;
      key_state_q  <= key_state_d;
      key_prev_q   <= key_state_q;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      evt_drop_q   <= |drop_vec;
      for (int i = 0; i < KEY_NUM; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign key_state = key_state_q;
  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_drop  = evt_drop_q;

endmodule

// File: tb/tb_key_event_arb.sv
// Self-checking bench for key_event_arb: directed scenarios plus randomized key and
// ready traffic, compared cycle by cycle against a behavioural model of the key panel.
module tb_key_event_arb;

  localparam int KN = 4;
  localparam int SC = 4;
  localparam int ST = 3;
  localparam int IW = 2;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic [KN-1:0] key_in    = '1;
  logic          evt_ready = 1'b0;
  logic [KN-1:0] key_state;
  logic          evt_valid;
  logic [IW-1:0] evt_id;
  logic          evt_drop;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  key_event_arb #(
    .KEY_NUM   (KN),
    .CLK_FRE   (50),
    .SCAN_CYC  (SC),
    .STABLE_CNT(ST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_state(key_state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .evt_drop (evt_drop)
  );

  // Behavioural panel model: pin history, run lengths of disagreeing scans,
  // a set of waiting keys and a rotating server.
  bit [KN-1:0] m_s1, m_s2, m_ks, m_ks_old, m_pend;
  int          m_run [KN];
  int          m_tick, m_last, m_id;
  bit          m_valid, m_drop;

  always @(posedge clk) begin : model
    bit [KN-1:0] rise;
    bit [1:0]    idx;
    bit          free;
    int          g;
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_ks = '0; m_ks_old = '0; m_pend = '0;
      for (int i = 0; i < KN; i++) m_run[i] = 0;
      m_tick = 0; m_last = KN - 1; m_id = 0; m_valid = 0; m_drop = 0;
    end else begin
      rise = m_ks & ~m_ks_old;
      free = !m_valid || evt_ready;
      g = -1;
      if (free) begin
        for (int k = 1; k <= KN; k++) begin
          idx = 2'((m_last + k) % KN);
          if (g < 0 && m_pend[idx]) g = int'(idx);
        end
      end
      m_drop = 0;
      for (int i = 0; i < KN; i++)
        if (rise[i] && m_pend[i] && i != g) m_drop = 1;
      if (g >= 0) m_pend[2'(g)] = 0;
      m_pend = m_pend | rise;
      if (free) begin
        m_valid = (g >= 0);
        if (g >= 0) begin m_id = g; m_last = g; end
      end
      m_ks_old = m_ks;
      if (m_tick == SC - 1) begin
        for (int i = 0; i < KN; i++) begin
          if (!m_s2[i] != m_ks[i]) begin
            m_run[i]++;
            if (m_run[i] == ST) begin m_ks[i] = !m_ks[i]; m_run[i] = 0; end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_tick = (m_tick + 1) % SC;
      m_s2 = m_s1;
      m_s1 = key_in;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    key_in = '1; evt_ready = 0; rst = 1;
    repeat (3) cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    key_in = '1; evt_ready = 0; rst = 1;
    repeat (3) cyc();
    tests++;
    if (key_state !== '0 || evt_valid !== 1'b0 || evt_drop !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got ks=%b v=%b drop=%b, want 0000 0 0", key_state, evt_valid, evt_drop);
    end
    rst = 0;
    for (int c = 0; c < 100; c++) begin
      cyc();
      tests++;
      if (key_state !== '0 || evt_valid !== 1'b0 || evt_drop !== 1'b0) begin
        fails++;
        $display("FAIL idle_quiet c=%0d: got ks=%b v=%b drop=%b, want 0000 0 0", c, key_state, evt_valid, evt_drop);
      end
    end
  endtask

  task automatic test_clean_press();
    int ks_at = -1;
    int v_at  = -1;
    do_reset();
    key_in = 4'b1011;
    for (int c = 0; c < 60 && v_at < 0; c++) begin
      cyc();
      tests++;
      if (key_state !== m_ks || evt_valid !== m_valid || evt_drop !== m_drop || (m_valid && evt_id !== IW'(m_id))) begin
        fails++;
        $display("FAIL press_model c=%0d: got ks=%b v=%b id=%0d drop=%b, want ks=%b v=%b id=%0d drop=%b",
                 c, key_state, evt_valid, evt_id, evt_drop, m_ks, m_valid, m_id, m_drop);
      end
      if (ks_at < 0 && key_state[2]) ks_at = c;
      if (evt_valid) v_at = c;
    end
    tests++;
    if (v_at < 0) begin
      fails++;
      $display("FAIL press_timeout: got no evt_valid in 60 cycles, want an event");
    end else begin
      tests++;
      if (evt_id !== 2'd2 || key_state !== 4'b0100) begin
        fails++;
        $display("FAIL press_event: got id=%0d ks=%b, want id=2 ks=0100", evt_id, key_state);
      end
      tests++;
      if (v_at - ks_at !== 2) begin
        fails++;
        $display("FAIL press_latency: got %0d cycles, want 2", v_at - ks_at);
      end
    end
    evt_ready = 1;
    cyc();
    tests++;
    if (evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL press_handshake: got evt_valid=%b, want 0", evt_valid);
    end
    evt_ready = 0;
    key_in = '1;
    repeat (30) cyc();
    tests++;
    if (key_state !== '0 || evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL release: got ks=%b v=%b, want 0000 0", key_state, evt_valid);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    evt_ready = 1;
    for (int c = 0; c < 20 * SC; c++) begin
      key_in = '1;
      key_in[1] = ((c / SC) % 2 == 1);
      cyc();
      tests++;
      if (key_state[1] !== 1'b0 || evt_valid !== 1'b0 || key_state !== m_ks || evt_valid !== m_valid) begin
        fails++;
        $display("FAIL bounce c=%0d: got ks=%b v=%b, want ks[1]=0 v=0 (model ks=%b)", c, key_state, evt_valid, m_ks);
      end
    end
    key_in = '1;
    repeat (30) cyc();
  endtask

  task automatic test_round_robin();
    int exp_seq [2] = '{1, 3};
    int waited = 0;
    do_reset();
    key_in = 4'b0100;
    while (!evt_valid && waited < 60) begin
      cyc();
      waited++;
      tests++;
      if (key_state !== m_ks || evt_valid !== m_valid || evt_drop !== m_drop || (m_valid && evt_id !== IW'(m_id))) begin
        fails++;
        $display("FAIL rr_model: got ks=%b v=%b id=%0d drop=%b, want ks=%b v=%b id=%0d drop=%b",
                 key_state, evt_valid, evt_id, evt_drop, m_ks, m_valid, m_id, m_drop);
      end
    end
    for (int c = 0; c < 3; c++) begin
      tests++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
        fails++;
        $display("FAIL rr_hold c=%0d: got v=%b id=%0d, want v=1 id=0", c, evt_valid, evt_id);
      end
      cyc();
    end
    evt_ready = 1;
    for (int j = 0; j < 2; j++) begin
      cyc();
      tests++;
      if (evt_valid !== 1'b1 || evt_id !== IW'(exp_seq[j])) begin
        fails++;
        $display("FAIL rr_seq%0d: got v=%b id=%0d, want v=1 id=%0d", j, evt_valid, evt_id, exp_seq[j]);
      end
    end
    cyc();
    tests++;
    if (evt_valid !== 1'b0) begin
      fails++;
      $display("FAIL rr_idle: got evt_valid=%b, want 0", evt_valid);
    end
    key_in = '1;
    repeat (30) cyc();
  endtask

  task automatic test_hold_drop();
    logic [KN-1:0] phases [3] = '{4'b1010, 4'b1110, 4'b1010};
    int drops = 0;
    int n2 = 0;
    int waited = 0;
    do_reset();
    key_in = 4'b1110;
    while (!evt_valid && waited < 60) begin
      cyc();
      waited++;
    end
    for (int ph = 0; ph < 3; ph++) begin
      key_in = phases[ph];
      for (int c = 0; c < 30; c++) begin
        cyc();
        drops += int'(evt_drop);
        tests++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0 || key_state !== m_ks || evt_drop !== m_drop) begin
          fails++;
          $display("FAIL hold ph=%0d c=%0d: got v=%b id=%0d ks=%b drop=%b, want v=1 id=0 ks=%b drop=%b",
                   ph, c, evt_valid, evt_id, key_state, evt_drop, m_ks, m_drop);
        end
      end
    end
    tests++;
    if (drops !== 1) begin
      fails++;
      $display("FAIL drop_count: got %0d pulses, want 1", drops);
    end
    evt_ready = 1;
    for (int c = 0; c < 10; c++) begin
      if (evt_valid && evt_id == 2'd2) n2++;
      cyc();
    end
    tests++;
    if (n2 !== 1) begin
      fails++;
      $display("FAIL key2_delivered: got %0d events, want 1", n2);
    end
    key_in = '1;
    repeat (30) cyc();
  endtask

  task automatic test_reset_midop();
    int waited = 0;
    do_reset();
    key_in = 4'b1110;
    while (!evt_valid && waited < 60) begin
      cyc();
      waited++;
    end
    key_in = 4'b0100;
    waited = 0;
    while (key_state !== 4'b1011 && waited < 60) begin
      cyc();
      waited++;
    end
    repeat (2) cyc();
    tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
      fails++;
      $display("FAIL midop_setup: got v=%b id=%0d, want v=1 id=0", evt_valid, evt_id);
    end
    rst = 1;
    key_in = '1;
    cyc();
    tests++;
    if (evt_valid !== 1'b0 || key_state !== '0) begin
      fails++;
      $display("FAIL midop_reset: got v=%b ks=%b, want v=0 ks=0000", evt_valid, key_state);
    end
    rst = 0;
    evt_ready = 1;
    for (int c = 0; c < 30; c++) begin
      cyc();
      tests++;
      if (evt_valid !== 1'b0) begin
        fails++;
        $display("FAIL midop_cleared c=%0d: got evt_valid=%b id=%0d, want 0", c, evt_valid, evt_id);
      end
    end
    evt_ready = 0;
    key_in = 4'b1100;
    waited = 0;
    while (!evt_valid && waited < 60) begin
      cyc();
      waited++;
    end
    tests++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
      fails++;
      $display("FAIL midop_first: got v=%b id=%0d, want v=1 id=0", evt_valid, evt_id);
    end
    key_in = '1;
    evt_ready = 1;
    repeat (30) cyc();
  endtask

  task automatic test_random();
    int hold = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        key_in = KN'($urandom);
        hold = int'($urandom_range(1, 40));
      end
      hold--;
      evt_ready = ($urandom_range(0, 3) != 0);
      cyc();
      tests++;
      if (key_state !== m_ks || evt_valid !== m_valid || evt_drop !== m_drop || (m_valid && evt_id !== IW'(m_id))) begin
        fails++;
        $display("FAIL random c=%0d: got ks=%b v=%b id=%0d drop=%b, want ks=%b v=%b id=%0d drop=%b",
                 c, key_state, evt_valid, evt_id, evt_drop, m_ks, m_valid, m_id, m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_round_robin();
    test_hold_drop();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_event_arb.md
Name: key_event_arb

Overview:
- Shared key-input controller for the multi-key front panel.
- Samples KEY_NUM raw key pins on one common scan timer.
- Debounces each key and turns every debounced press into a queued event.
- Arbitrates pending events round-robin onto a single valid/ready event stream for the downstream LED/menu logic, so that logic sees one key event at a time.

Parameters:
- KEY_NUM, 4, number of key inputs (2..16).
- CLK_FRE, 50, clock frequency in MHz.
- SCAN_CYC, CLK_FRE*1000, clock cycles per scan tick (default gives 1 ms).
- STABLE_CNT, 20, consecutive differing ticks required to change a debounced state (>=2).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- key_in, input, KEY_NUM, raw key pins, active-low (0 = pressed), asynchronous.
- key_state, output, KEY_NUM, debounced level, 1 = pressed.
- evt_valid, output, 1, an event is presented.
- evt_ready, input, 1, consumer accepts the event.
- evt_id, output, $clog2(KEY_NUM), index of the key that produced the event.
- evt_drop, output, 1, one-cycle pulse when a press is lost because that key's event is already pending.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Synchronizer flops are set to 1 (released).
  - key_state, pending, evt_valid, evt_id, evt_drop and all counters are cleared to 0.
  - last_grant is set to KEY_NUM-1, so key 0 has first priority.
  - Reset mid-operation discards pending events and any presented event immediately; evt_valid is 0 in the cycle after reset.
- Input sync:
  - Each key_in passes through a 2-flop synchronizer.
  - The sampled value is p[i] = ~sync[i].
- Scan timer:
  - tick_cnt counts 0..SCAN_CYC-1 and wraps.
  - tick is asserted for one cycle when tick_cnt == SCAN_CYC-1.
- Debounce, evaluated per key only on tick cycles:
  - If p[i] == key_state[i]: deb_cnt[i] <= 0.
  - Otherwise: deb_cnt[i] increments.
  - When deb_cnt[i] == STABLE_CNT-1 and p[i] still differs: key_state[i] toggles and deb_cnt[i] <= 0.
  - Net effect: a level must differ on STABLE_CNT consecutive ticks to be accepted. A single agreeing tick restarts the count.
- Press detection and queueing:
  - The registered key_state rising edge (0->1) produces a press strobe for key i.
  - The strobe sets pending[i] on the next edge.
  - Releases generate no event.
  - If pending[i] is already 1 and is not being granted in that cycle, evt_drop pulses for 1 cycle and pending[i] stays 1.
- Output slot: free when evt_valid==0, or when evt_valid && evt_ready in the current cycle.
- Round-robin arbitration: when the slot is free and pending != 0:
  - Search pending starting at last_grant+1 (mod KEY_NUM).
  - The first set bit g is granted: evt_valid<=1, evt_id<=g, last_grant<=g, pending[g]<=0.
  - Back-to-back transfers are supported: one event per cycle while evt_ready=1.
- Hold rule: while evt_valid && !evt_ready, evt_valid and evt_id are held stable and no new grant occurs.
- Idle rule: evt_valid drops to 0 after a handshake when pending==0.
- Simultaneous events:
  - A press strobe on key g in the same cycle g is granted leaves pending[g]=1 (set wins, no drop).
  - Multiple keys pressing in the same cycle all set their pending bits in that cycle.
- Latency: evt_valid rises 2 cycles after the key_state edge when the slot is idle (press strobe -> pending -> evt_valid).
- Widths:
  - tick_cnt is $clog2(SCAN_CYC) bits.
  - deb_cnt is $clog2(STABLE_CNT) bits per key.
  - All counters wrap or clear exactly as stated, never saturate.

Test Plan (SCAN_CYC=4, STABLE_CNT=3, KEY_NUM=4):
- Reset/idle: hold rst=1 for 3 cycles, key_in=4'hF.
  -> key_state=0, evt_valid=0 and evt_drop=0 for 100 cycles after release.
- Clean press: drive key_in[2]=0 and hold.
  -> key_state[2]=1 after the 3rd tick plus 1 cycle.
  -> evt_valid=1 with evt_id=2 two cycles later.
  -> with evt_ready=1, evt_valid falls the next cycle.
- Bounce: toggle key_in[1] on alternating ticks for 20 ticks.
  -> key_state[1] stays 0 and no event is produced.
- Round-robin: press keys 0, 1 and 3 simultaneously with evt_ready=0, then raise evt_ready.
  -> evt_id sequence is 0, 1, 3 on consecutive cycles, then evt_valid=0.
- Hold/drop: with evt_ready=0 and key 0 presented, press keys 2, release, press keys 2 again.
  -> evt_id stays 0.
  -> evt_drop pulses once on the second key 2 press.
  -> after ready, key 2 is delivered exactly once.
- Reset mid-op: assert rst with evt_valid=1 and pending=4'b1010.
  -> the next cycle shows evt_valid=0, pending cleared, and the first later press of key 0 is granted first.
